// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver: scans DIGITS digits with a per-slot guard
// time, optional leading-zero blanking and a double-buffered load interface.
module seg7_scan_driver #(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned DIV            = 50000,
   parameter int unsigned GUARD          = 1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          LZB            = 1'b0
) (
   input  logic                  sysclk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp_in,
   output logic [6:0]            cathodes,
   output logic                  dp,
   output logic [DIGITS-1:0]     AN,
   output logic                  frame_done,
   output logic                  pending
);

   localparam int unsigned DW = 4 * DIGITS;
   localparam int unsigned PW = $clog2(DIV);
   localparam int unsigned IW = $clog2(DIGITS);
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
   localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);
   localparam logic [PW-1:0] GCNT = PW'(GUARD);

   logic [PW-1:0]     pcnt;
   logic [IW-1:0]     idx;
   logic [DW-1:0]     pend_data;
   logic [DIGITS-1:0] pend_dp;
   logic [DW-1:0]     disp_data;
   logic [DIGITS-1:0] disp_dp;

   logic              tick;
   logic              wrap;
   logic              commit;
   logic [3:0]        nib;
   logic [DW-1:0]     upper;
   logic              blank;
   logic [6:0]        seg_on;
   logic [DIGITS-1:0] an_on;
   logic [6:0]        cathodes_c;
   logic              dp_c;
   logic [DIGITS-1:0] an_c;

   // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
   function automatic logic [6:0] hex2seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Slot tick, frame boundary and commit qualifiers.
   always_comb begin
      tick   = (pcnt == PMAX);
      wrap   = tick && (idx == IMAX);
      commit = wrap && pending;
   end

   // Prescaler and digit index.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         pcnt <= '0;
         idx  <= '0;
      end else if (tick) begin
         pcnt <= '0;
         idx  <= (idx == IMAX) ? '0 : idx + 1'b1;
      end else begin
         pcnt <= pcnt + 1'b1;
      end
   end

   // Pending/display double buffer; a load coinciding with a commit is kept pending.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         pend_data  <= '0;
         pend_dp    <= '0;
         disp_data  <= '0;
         disp_dp    <= '0;
         pending    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         if (load) begin
            pend_data <= data;
            pend_dp   <= dp_in;
         end
         if (commit) begin
            disp_data <= pend_data;
            disp_dp   <= pend_dp;
         end
         pending    <= load | (pending & ~commit);
         frame_done <= commit;
      end
   end

   // Segment, decimal-point and anode values for the current slot.
   always_comb begin
      nib        = disp_data[{idx, 2'b00} +: 4];
      upper      = disp_data >> {idx, 2'b00};
      blank      = LZB && (idx != '0) && (upper == '0);
      seg_on     = blank ? 7'h00 : hex2seg(nib);
      an_on      = (pcnt < GCNT) ? '0 : (DIGITS'(1) << idx);
      cathodes_c = seg_on ^ {7{SEG_ACTIVE_LOW}};
      dp_c       = disp_dp[idx] ^ SEG_ACTIVE_LOW;
      an_c       = an_on ^ {DIGITS{AN_ACTIVE_LOW}};
   end

   // Registered pin drivers, all inactive in reset.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         cathodes <= {7{SEG_ACTIVE_LOW}};
         dp       <= SEG_ACTIVE_LOW;
         AN       <= {DIGITS{AN_ACTIVE_LOW}};
      end else begin
         cathodes <= cathodes_c;
         dp       <= dp_c;
         AN       <= an_c;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4-cycle slots, 1-cycle guard,
// active-low pins; one instance without and one with leading-zero blanking.
module tb_seg7_scan_driver;

   logic        sysclk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] data;
   logic [3:0]  dp_in;

   logic [6:0]  cath0, cath1;
   logic        dp0, dp1;
   logic [3:0]  an0, an1;
   logic        fd0, fd1;
   logic        pend0, pend1;

   int checks = 0;
   int errors = 0;
   int k      = 0;

   always #5 sysclk = ~sysclk;

   seg7_scan_driver #(.DIGITS(4), .DIV(4), .GUARD(1), .AN_ACTIVE_LOW(1'b1),
                      .SEG_ACTIVE_LOW(1'b1), .LZB(1'b0)) dut (
      .sysclk(sysclk), .reset(reset), .load(load), .data(data), .dp_in(dp_in),
      .cathodes(cath0), .dp(dp0), .AN(an0), .frame_done(fd0), .pending(pend0));

   seg7_scan_driver #(.DIGITS(4), .DIV(4), .GUARD(1), .AN_ACTIVE_LOW(1'b1),
                      .SEG_ACTIVE_LOW(1'b1), .LZB(1'b1)) dut_lzb (
      .sysclk(sysclk), .reset(reset), .load(load), .data(data), .dp_in(dp_in),
      .cathodes(cath1), .dp(dp1), .AN(an1), .frame_done(fd1), .pending(pend1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, k);
      end
   endtask

   // One 16-cycle frame; k counts negedges since reset release, so the state
   // seen at negedge k is pcnt=(k-1)%4, idx=((k-1)/4)%4.
   task automatic run_frame(input logic [27:0] segs, input logic [27:0] lsegs,
                            input logic [3:0] dps, input logic fd_end, input logic pend_end,
                            input int p1, input logic [15:0] v1, input logic [3:0] d1,
                            input int p2, input logic [15:0] v2, input int stop_at);
      int slot;
      int pos;
      logic [3:0] exp_an;
      for (int i = 1; i <= 16; i++) begin
         @(negedge sysclk);
         k++;
         slot   = ((k - 1) / 4) % 4;
         pos    = (k - 1) % 4;
         exp_an = (pos == 0) ? 4'hF : ~(4'b0001 << slot);
         chk("an", 32'(an0), 32'(exp_an));
         chk("an_lzb", 32'(an1), 32'(exp_an));
         chk("cathodes", 32'(cath0), 32'(segs[slot*7 +: 7]));
         chk("cathodes_lzb", 32'(cath1), 32'(lsegs[slot*7 +: 7]));
         chk("dp", 32'(dp0), 32'(dps[slot]));
         chk("frame_done", 32'(fd0), (i == 16) ? 32'(fd_end) : 32'd0);
         if (i == 16) chk("pending_end", 32'(pend0), 32'(pend_end));
         if (p1 > 0 && i == p1 + 1) chk("pending_after_load", 32'(pend0), 32'd1);
         load = 1'b0;
         if (i == p1) begin load = 1'b1; data = v1; dp_in = d1; end
         if (i == p2) begin load = 1'b1; data = v2; dp_in = 4'h0; end
         if (i == stop_at) return;
      end
   endtask

   localparam logic [27:0] ZERO  = {4{7'h40}};
   localparam logic [27:0] LZERO = {7'h7F, 7'h7F, 7'h7F, 7'h40};
   localparam logic [27:0] S12AF = {7'h79, 7'h24, 7'h08, 7'h0E};
   localparam logic [27:0] ONES  = {4{7'h79}};
   localparam logic [27:0] TWOS  = {4{7'h24}};
   localparam logic [27:0] S0042 = {7'h40, 7'h40, 7'h19, 7'h24};
   localparam logic [27:0] L0042 = {7'h7F, 7'h7F, 7'h19, 7'h24};

   initial begin
      reset = 1'b0;
      load  = 1'b0;
      data  = 16'h0;
      dp_in = 4'h0;

      // reset state
      repeat (2) @(negedge sysclk);
      chk("rst_an", 32'(an0), 32'hF);
      chk("rst_cathodes", 32'(cath0), 32'h7F);
      chk("rst_dp", 32'(dp0), 32'd1);
      chk("rst_pending", 32'(pend0), 32'd0);
      chk("rst_frame_done", 32'(fd0), 32'd0);
      chk("rst_an_lzb", 32'(an1), 32'hF);
      chk("rst_cathodes_lzb", 32'(cath1), 32'h7F);

      // load during reset is ignored
      load  = 1'b1;
      data  = 16'hFFFF;
      dp_in = 4'hF;
      @(negedge sysclk);
      load  = 1'b0;
      dp_in = 4'h0;
      chk("rst_load_pending", 32'(pend0), 32'd0);
      reset = 1'b1;
      k     = 0;

      // two idle frames: scan order, guard, blank display
      run_frame(ZERO, LZERO, 4'hF, 1'b0, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 0);
      run_frame(ZERO, LZERO, 4'hF, 1'b0, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 0);

      // mid-frame load commits at the boundary, then displays
      run_frame(ZERO, LZERO, 4'hF, 1'b1, 1'b0, 4, 16'h12AF, 4'b0100, 0, 16'h0, 0);
      run_frame(S12AF, S12AF, 4'b1011, 1'b0, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 0);

      // load 1111 then 2222 exactly on the commit cycle
      run_frame(S12AF, S12AF, 4'b1011, 1'b1, 1'b1, 5, 16'h1111, 4'h0, 15, 16'h2222, 0);
      run_frame(ONES, ONES, 4'hF, 1'b1, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 0);

      // leading-zero blanking
      run_frame(TWOS, TWOS, 4'hF, 1'b1, 1'b0, 3, 16'h0042, 4'h0, 0, 16'h0, 0);
      run_frame(S0042, L0042, 4'hF, 1'b1, 1'b0, 3, 16'h0000, 4'h0, 0, 16'h0, 0);

      // mid-frame reset during slot 2 with data pending
      run_frame(ZERO, LZERO, 4'hF, 1'b0, 1'b0, 2, 16'h5555, 4'hF, 0, 16'h0, 10);
      chk("pre_reset_pending", 32'(pend0), 32'd1);
      chk("pre_reset_an", 32'(an0), 32'hB);
      reset = 1'b0;
      #1;
      chk("async_an", 32'(an0), 32'hF);
      chk("async_cathodes", 32'(cath0), 32'h7F);
      chk("async_dp", 32'(dp0), 32'd1);
      chk("async_pending", 32'(pend0), 32'd0);
      chk("async_an_lzb", 32'(an1), 32'hF);
      @(negedge sysclk);
      @(negedge sysclk);
      reset = 1'b1;
      k     = 0;
      run_frame(ZERO, LZERO, 4'hF, 1'b0, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, multi-digit multiplexed seven-segment driver that produces the `cathodes`/`AN` outputs of the CPU top level. It replaces the fixed 4-digit `ledclk`/`cnt` scan path with configurable digit count, scan rate, polarity, per-digit decimal points, anti-ghosting guard time, leading-zero blanking and a tear-free double-buffered load interface. It sits between the CPU's display-data register and the board pins.

## Interface
- `DIGITS`, 4: number of digits scanned (2–8).
- `DIV`, 50000: `sysclk` cycles per digit slot (≥ 2).
- `GUARD`, 1: cycles at the start of each slot with all anodes off (0 ≤ GUARD < DIV).
- `AN_ACTIVE_LOW`, 1: 1 means an anode is enabled by driving 0.
- `SEG_ACTIVE_LOW`, 1: 1 means a segment/dp is lit by driving 0.
- `LZB`, 0: 1 enables leading-zero blanking.

- `sysclk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `load` in 1: one-cycle strobe; captures `data`/`dp_in` into the pending buffer.
- `data` in 4*DIGITS: hex nibbles; digit i = `data[4i+3:4i]`; digit 0 is rightmost.
- `dp_in` in DIGITS: decimal point per digit, 1 = lit.
- `cathodes` out 7: {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- `dp` out 1: decimal point of the active digit.
- `AN` out DIGITS: one-hot digit enable, polarity per AN_ACTIVE_LOW.
- `frame_done` out 1: one-cycle pulse when a frame boundary commits pending data.
- `pending` out 1: 1 while loaded data awaits commit.

## Operation
- Prescaler `pcnt`, width clog2(DIV), counts 0..DIV-1 and wraps. A tick occurs in the cycle where pcnt = DIV-1.
- Digit index `idx` advances on tick, 0→1→…→DIGITS-1→0.
- Frame boundary: the tick on which idx wraps DIGITS-1→0.
- Pending buffer: `load` writes data/dp_in into it and sets `pending`. Successive loads overwrite; the last one wins.
- Commit: at a frame boundary with `pending`=1, the pending buffer is copied to the display buffer, `pending` clears, and `frame_done` pulses the following cycle. With `pending`=0, there is no copy and no pulse.
- Simultaneous `load` and commit: the previously pending value commits, the new value is captured, and `pending` stays 1.
- Hex decode (active-high a..g, before polarity): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- LZB=1: digits above the most-significant nonzero nibble are blanked (segments off; dp still honoured). Digit 0 is never blanked, so data 0 displays "0".
- Guard: while pcnt < GUARD, all anodes are inactive. Otherwise only AN[idx] is active.

## Timing
- All outputs are registered and reflect the idx/pcnt/display state of the previous cycle, giving one cycle of latency.
- Slot length is DIV cycles: GUARD cycles dark, then DIV-GUARD cycles lit. Frame length is DIGITS*DIV cycles.
- Worst-case load-to-display latency is DIGITS*DIV + 1 cycles. A load never alters a frame in progress.
- Reset (async assert, any time, including mid-frame or mid-load): pcnt=0, idx=0, display buffer=0, pending buffer=0, `pending`=0, `frame_done`=0. Outputs are inactive: `AN` all off (all 1s when active-low), `cathodes` all off (7'h7F when active-low), `dp` off.
- Release is synchronous to `sysclk`. Counting starts on the first edge after deassertion, and slot 0 begins with its guard period.
- A `load` during reset is ignored.

## Test plan
- Reset values: DIGITS=4, DIV=4, GUARD=1, active-low. Hold `reset`=0 → AN=4'hF, cathodes=7'h7F, dp=1, pending=0. Release → AN stays 4'hF for 2 cycles (latency + guard), then AN=4'hE, cathodes=7'h40 ("0").
- Scan order and guard: run 2 frames → AN sequence E,D,B,7 with each value held 3 cycles and preceded by 1 cycle of F. Frame = 16 cycles.
- Load and commit: load data=16'h12AF, dp_in=4'b0100 mid-frame → `pending`=1 and the display stays 0000 until the boundary. Then `frame_done` pulses once and the next frame shows cathodes 0E (F), 08 (A), 24 (2) with dp=0, and 79 (1).
- Load colliding with the boundary: load 16'h1111, then load 16'h2222 in the exact commit cycle → 1111 is displayed for one frame, `pending` stays 1, 2222 commits at the next boundary, and `frame_done` pulses twice in total.
- LZB=1, data=16'h0042 → digits 3 and 2 are off (7'h7F) with AN still scanning; digit 1 shows 7'h19 ("4"), digit 0 shows 7'h24 ("2"). data=0 → only digit 0 is lit, showing 7'h40.
- Mid-frame reset: assert `reset` during slot 2 with `pending`=1 → outputs go off asynchronously in the same cycle and `pending`=0. After release, the display shows 0000 and the scan restarts at digit 0.
